// File: rtl/scan_sequencer.sv
// Walks a 3-bit decoder select from `first` to `last` in either direction,
// holding each position for dwell+1 cycles; every output is a register.
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [2:0]         first,
  input  logic [2:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic [2:0]           last_q, last_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      last_q  <= 3'd0;
      dwell_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // done and wrap default low so they can only ever be single-cycle pulses.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          dir_d   = dir;
          last_d  = last;
          dwell_d = dwell;
          sel_d   = first;
          cnt_d   = dwell;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sel_q != last_q) begin
          sel_d  = dir_q ? sel_q + 3'd1 : sel_q - 3'd1;
          cnt_d  = dwell_q;
          wrap_d = dir_q ? (sel_q == 3'd7) : (sel_q == 3'd0);
        end else begin
          state_d = FIN;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sel         = sel_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrap        = wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a reference model fills an expected {wrap,sel}
// queue per scan, which is drained one entry per enabled cycle.
module tb_scan_sequencer;

  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               dir;
  logic [2:0]         first;
  logic [2:0]         last;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               done;
  logic               wrap;
  logic [1:0]         dbg_state;

  logic [3:0] exp_q[$];
  int n_checks;
  int n_pass;

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .first       (first),
    .last        (last),
    .dwell       (dwell),
    .sel         (sel),
    .en          (en),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: one {wrap,sel} entry per cycle en is expected high.
  task automatic build_expected(input logic [2:0] f, input logic [2:0] l, input logic d,
                                input logic [DWELL_W-1:0] dw);
    logic [2:0] s;
    logic       w;
    s = f;
    w = 1'b0;
    exp_q.delete();
    for (int pos = 0; pos < 8; pos++) begin
      for (int k = 0; k <= int'(dw); k++) begin
        exp_q.push_back({(k == 0) ? w : 1'b0, s});
      end
      if (s == l) break;
      w = d ? (s == 3'd7) : (s == 3'd0);
      s = d ? s + 3'd1 : s - 3'd1;
    end
  endtask

  task automatic kick(input logic [2:0] f, input logic [2:0] l, input logic d,
                      input logic [DWELL_W-1:0] dw);
    first = f;
    last  = l;
    dir   = d;
    dwell = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full scan with inputs scrambled and start poked during RUN; the scan must
  // follow only the values latched at start.
  task automatic do_scan(input logic [2:0] f, input logic [2:0] l, input logic d,
                         input logic [DWELL_W-1:0] dw);
    logic [3:0] e;
    int budget;
    build_expected(f, l, d, dw);
    kick(f, l, d, dw);
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      e = exp_q.pop_front();
      check("run_en", en, 1);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_wrap_sel", {wrap, sel}, e);
      start = ($urandom_range(0, 3) == 0);
      first = 3'($urandom_range(0, 7));
      last  = 3'($urandom_range(0, 7));
      dir   = 1'($urandom_range(0, 1));
      dwell = DWELL_W'($urandom_range(0, 15));
      @(negedge clk);
      budget--;
    end
    check("scan_budget", (budget > 0), 1);
    check("fin_done", done, 1);
    check("fin_en", en, 0);
    check("fin_busy", busy, 0);
    check("fin_sel", sel, l);
    start = 1'b1;
    first = 3'd0;
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_en", en, 0);
    check("post_state_idle", dbg_state, 0);
    check("idle_sel_hold", sel, l);
    @(negedge clk);
  endtask

  task automatic wait_sel(input logic [2:0] target);
    int budget;
    budget = 100;
    while (!(en && sel == target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_sel_budget", (budget > 0), 1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b1;
    first = 3'd0;
    last  = 3'd0;
    dwell = '0;
    #2;
    check("rst_sel", sel, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed scans: ascending full, dwell, descending wrap, single position.
    do_scan(3'd0, 3'd7, 1'b1, 4'd0);
    do_scan(3'd2, 3'd4, 1'b1, 4'd2);
    do_scan(3'd1, 3'd6, 1'b0, 4'd0);
    do_scan(3'd6, 3'd1, 1'b1, 4'd1);
    do_scan(3'd3, 3'd3, 1'b0, 4'd15);

    // start with stop held in IDLE stays idle
    first = 3'd5;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("prio_en", en, 0);
    check("prio_busy", busy, 0);
    check("prio_state", dbg_state, 0);
    @(negedge clk);

    // Abort at sel=3 holds sel and gives no done.
    kick(3'd0, 3'd7, 1'b1, 4'd1);
    wait_sel(3'd3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_en", en, 0);
    check("abort_busy", busy, 0);
    check("abort_sel", sel, 3);
    check("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {done, en, sel}, {1'b0, 1'b0, 3'd3});
    end

    // Async reset mid-scan acts before the next edge.
    kick(3'd0, 3'd7, 1'b1, 4'd1);
    wait_sel(3'd5);
    rst = 1'b1;
    #1;
    check("arst_sel", sel, 0);
    check("arst_en", en, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    do_scan(3'd4, 3'd4, 1'b1, 4'd2);

    // Random scans.
    for (int n = 0; n < 6; n++) begin
      do_scan(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), DWELL_W'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of the dwell count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a scan when idle.
REQ-005 SHALL have port stop  input  1  abort a scan in progress.
REQ-006 SHALL have port dir  input  1  scan direction; 1 = ascending, 0 = descending.
REQ-007 SHALL have port first  input  3  first select value of the scan.
REQ-008 SHALL have port last  input  3  final select value of the scan.
REQ-009 SHALL have port dwell  input  DWELL_W  extra cycles each select is held.
REQ-010 SHALL have port sel  output  3  select value driving the downstream 3-to-8 decoder input.
REQ-011 SHALL have port en  output  1  enable driving the downstream decoder enable.
REQ-012 SHALL have port busy  output  1  high while a scan is running.
REQ-013 SHALL have port done  output  1  one-cycle pulse on normal scan completion.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse when sel wraps 7->0 or 0->7.

Function
REQ-015 SHALL implement states IDLE, RUN, FIN.
REQ-016 SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-017 IDLE with start=1 and stop=0 SHALL: latch dir, last and dwell; load sel<=first and cnt<=dwell; set en=1 and busy=1; go to RUN.
REQ-018 IDLE with start=1 and stop=1 SHALL keep the block in IDLE, with stop taking priority.
REQ-019 RUN with cnt!=0 SHALL decrement cnt and hold sel, so each select is held for exactly dwell+1 cycles.
REQ-020 RUN with cnt==0 and sel!=latched last SHALL: step sel by +1 (dir=1) or -1 (dir=0) modulo 8; reload cnt<=latched dwell.
REQ-021 RUN with cnt==0 and sel==latched last SHALL go to FIN, with en=0, busy=0 and done=1 for one cycle.
REQ-022 FIN SHALL return to IDLE on the next cycle with done=0, and SHALL ignore start while in FIN.
REQ-023 stop=1 in RUN SHALL, on the next edge: go to IDLE; set en=0 and busy=0; hold sel at its current value; assert no done.
REQ-024 start while in RUN SHALL be ignored.
REQ-025 Changes on dir, first, last or dwell during RUN SHALL have no effect until the next start.
REQ-026 wrap SHALL pulse for exactly the cycle after a step from 7 to 0 (ascending) or from 0 to 7 (descending), and SHALL otherwise be 0.
REQ-027 first==last SHALL give a single-position scan: dwell+1 cycles of en=1, then done.
REQ-028 A full scan SHALL last (N)*(dwell+1) RUN cycles, where N = positions visited including wrap, and N=1..8.
REQ-029 In IDLE, sel SHALL hold its last value and en SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force: state=IDLE, sel=0, cnt=0, en=0, busy=0, done=0, wrap=0.
REQ-031 rst asserted mid-scan SHALL abort the scan without a done pulse.
REQ-032 After rst is released, the first start SHALL begin a fresh scan.

Verification
REQ-033 Ascending full scan: first=0, last=7, dir=1, dwell=0, start pulse -> sel 0..7 on consecutive cycles, en=1 for 8 cycles, then done=1 for one cycle; wrap never set.
REQ-034 Dwell: first=2, last=4, dir=1, dwell=2 -> sel=2,2,2,3,3,3,4,4,4 (9 cycles), then done.
REQ-035 Descending wrap: first=1, last=6, dir=0, dwell=0 -> sel=1,0,7,6; wrap=1 in the cycle sel first shows 7; then done.
REQ-036 Abort: first=0, last=7, dwell=1, stop asserted on the cycle sel=3 -> next cycle en=0, busy=0, sel=3; done stays 0.
REQ-037 Async reset mid-scan: rst pulsed between clock edges while sel=5 -> sel=0, en=0, busy=0 before the next edge; subsequent start with first=4, last=4 -> sel=4 for dwell+1 cycles, then done.
REQ-038 Priority and ignore: start=1 with stop=1 in IDLE -> remains IDLE; start pulsed during RUN -> sequence unchanged.
